// File: rtl/shift_register_sequencer_if.sv
// Command, register-drive and serial-stream bundle for the
// shift register sequencer.
interface shift_register_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_data;
   logic [2:0] cmd_count;
   logic       cmd_fill;
   logic [3:0] reg_q;
   logic [1:0] reg_s;
   logic [3:0] reg_d;
   logic       reg_shr_in;
   logic       reg_shl_in;
   logic       reg_clr;
   logic       ser_out;
   logic       ser_valid;
   logic       done;
   logic [3:0] result;

   // command source plus register datapath side
   modport master (
      output cmd_valid, cmd_op, cmd_data,
      output cmd_count, cmd_fill, reg_q,
      input  cmd_ready, reg_s, reg_d,
      input  reg_shr_in, reg_shl_in, reg_clr,
      input  ser_out, ser_valid, done, result
   );

   // sequencer side
   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      input  cmd_count, cmd_fill, reg_q,
      output cmd_ready, reg_s, reg_d,
      output reg_shr_in, reg_shl_in, reg_clr,
      output ser_out, ser_valid, done, result
   );
endinterface

// File: rtl/shift_register_sequencer.sv
// Sequencer for a 4-bit universal shift register: each command is
// a parallel load followed by 0-4 shift or rotate steps.
module shift_register_sequencer (
   input logic                        clk,
   input logic                        reset,
   shift_register_sequencer_if.slave  bus
);

   localparam logic [2:0] S_INIT  = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0] r_state;
   logic [1:0] r_op;
   logic [3:0] r_data;
   logic       r_fill;
   logic [2:0] r_cnt;

   logic [2:0] w_sat;
   logic       w_right;
   logic       w_rot;
   logic       w_ready;
   logic [1:0] w_s;
   logic [3:0] w_d;
   logic       w_shr;
   logic       w_shl;
   logic       w_sout;
   logic       w_sval;
   logic       w_done;
   logic [3:0] w_res;

   assign w_sat   = (bus.cmd_count > 3'd4) ? 3'd4 : bus.cmd_count;
   // op[0]=0 moves right, op[1]=1 rotates
   assign w_right = ~r_op[0];
   assign w_rot   = r_op[1];

   // state walk and command capture; remaining count is the step budget
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_INIT;
         r_op    <= 2'b00;
         r_data  <= 4'd0;
         r_fill  <= 1'b0;
         r_cnt   <= 3'd0;
      end else begin
         case (r_state)
            S_INIT: r_state <= S_IDLE;
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_op    <= bus.cmd_op;
                  r_data  <= bus.cmd_data;
                  r_fill  <= bus.cmd_fill;
                  r_cnt   <= w_sat;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_state <= (r_cnt != 3'd0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
               r_cnt <= r_cnt - 3'd1;
               if (r_cnt == 3'd1) r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_INIT;
         endcase
      end
   end

   // output decode from registered state and command fields
   always_comb begin
      w_ready = 1'b0;
      w_s     = 2'b00;
      w_d     = 4'd0;
      w_shr   = 1'b0;
      w_shl   = 1'b0;
      w_sout  = 1'b0;
      w_sval  = 1'b0;
      w_done  = 1'b0;
      w_res   = 4'd0;
      case (r_state)
         S_IDLE: w_ready = 1'b1;
         S_LOAD: begin
            w_s = 2'b01;
            w_d = r_data;
         end
         S_SHIFT: begin
            w_sval = 1'b1;
            if (w_right) begin
               w_s    = 2'b10;
               w_shr  = w_rot ? bus.reg_q[0] : r_fill;
               w_sout = bus.reg_q[0];
            end else begin
               w_s    = 2'b11;
               w_shl  = w_rot ? bus.reg_q[3] : r_fill;
               w_sout = bus.reg_q[3];
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_res  = bus.reg_q;
         end
         default: ;
      endcase
   end

   assign bus.cmd_ready  = w_ready;
   assign bus.reg_s      = w_s;
   assign bus.reg_d      = w_d;
   assign bus.reg_shr_in = w_shr;
   assign bus.reg_shl_in = w_shl;
   assign bus.ser_out    = w_sout;
   assign bus.ser_valid  = w_sval;
   assign bus.done       = w_done;
   assign bus.result     = w_res;
   // clear follows reset combinationally so the register clears
   // on every edge while reset is held
   assign bus.reg_clr    = reset | (r_state == S_INIT);

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Scoreboard bench: behavioural shift register plus a reference
// model of each command's serial stream, result and done timing.
module tb_shift_register_sequencer;

   logic clk;
   logic reset;
   int   cyc;
   int   n_checks;
   int   n_err;
   int   ser_seen;
   int   done_seen;
   logic [3:0] last_res;
   int   last_acc;

   typedef struct {
      logic [3:0] res;
      int         dcyc;
   } exp_t;

   exp_t res_q[$];
   bit   ser_q[$];

   shift_register_sequencer_if bus ();

   shift_register_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // free-running cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // the external universal shift register
   always @(posedge clk) begin
      if (bus.reg_clr) bus.reg_q <= 4'd0;
      else begin
         case (bus.reg_s)
            2'b01: bus.reg_q <= bus.reg_d;
            2'b10: bus.reg_q <= {bus.reg_shr_in, bus.reg_q[3:1]};
            2'b11: bus.reg_q <= {bus.reg_q[2:0], bus.reg_shl_in};
            default: ;
         endcase
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   // reference: what a command must produce, from the op rules
   task automatic push_exp(input logic [1:0] op,
                           input logic [3:0] d,
                           input logic [2:0] c,
                           input logic f,
                           input int acc_cyc,
                           output logic [3:0] res);
      int n, v, r, b;
      exp_t e;
      n = (c > 3'd4) ? 4 : int'(c);
      v = int'(d);
      r = 0;
      case (op)
         2'd0: r = (v >> n) | (f ? ((15 << (4 - n)) & 15) : 0);
         2'd1: r = ((v << n) & 15) | (f ? ((1 << n) - 1) : 0);
         2'd2: r = ((v >> n) | (v << (4 - n))) & 15;
         default: r = ((v << n) | (v >> (4 - n))) & 15;
      endcase
      for (int k = 0; k < n; k++) begin
         b = (op[0] == 1'b0) ? ((v >> k) & 1) : ((v >> (3 - k)) & 1);
         ser_q.push_back(b[0]);
      end
      res = r[3:0];
      e.res = res;
      e.dcyc = acc_cyc + n + 1;
      res_q.push_back(e);
   endtask

   // monitor: pops expectations whenever the DUT presents output
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.ser_valid) begin
            ser_seen++;
            if (ser_q.size() == 0) chk("ser_unexpected", 1, 0);
            else chk("ser_out", int'(bus.ser_out), int'(ser_q.pop_front()));
         end
         if (bus.done) begin
            done_seen++;
            last_res = bus.result;
            if (res_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               exp_t e;
               e = res_q.pop_front();
               chk("result", int'(bus.result), int'(e.res));
               chk("done_cycle", cyc, e.dcyc);
               chk("ser_missing", ser_q.size(), 0);
            end
         end
      end
   end

   // presents a command, waits for acceptance, leaves valid high
   task automatic send(input logic [1:0] op, input logic [3:0] d,
                       input logic [2:0] c, input logic f,
                       output logic [3:0] res);
      bit acc;
      @(negedge clk);
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      bus.cmd_count = c;
      bus.cmd_fill  = f;
      bus.cmd_valid = 1'b1;
      acc = 0;
      res = 4'd0;
      for (int t = 0; t < 40; t++) begin
         if (bus.cmd_ready) begin
            acc = 1;
            break;
         end
         @(negedge clk);
      end
      if (!acc) begin
         chk("accept_timeout", 0, 1);
         bus.cmd_valid = 1'b0;
      end else begin
         last_acc = cyc + 1;
         push_exp(op, d, c, f, last_acc, res);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         #1;
         if (res_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chk("done_timeout", 0, 1);
         res_q.delete();
         ser_q.delete();
      end
   endtask

   function automatic logic [22:0] outs();
      return {bus.reg_clr, bus.cmd_ready, bus.done, bus.ser_valid,
              bus.ser_out, bus.reg_s, bus.reg_d, bus.reg_shr_in,
              bus.reg_shl_in, bus.result, 6'd0};
   endfunction

   localparam logic [22:0] RST_OUTS = 23'h400000;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r;
      logic [1:0] op;
      logic [3:0] d;
      logic [2:0] c;
      logic f;
      int a1, a2, n2, s0, d0;
      cyc = 0; n_checks = 0; n_err = 0;
      ser_seen = 0; done_seen = 0; last_res = 4'd0; last_acc = 0;
      reset = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 2'd1;
      bus.cmd_data = 4'hA;
      bus.cmd_count = 3'd2;
      bus.cmd_fill = 1'b1;

      // reset held 3 cycles with a command waiting
      repeat (3) begin
         @(negedge clk);
         chk("reset_outs", int'(outs()), int'(RST_OUTS));
         chk("reset_reg_q", int'(bus.reg_q), 0);
      end
      #1;
      reset = 1'b0;
      bus.cmd_valid = 1'b0;
      #1;
      chk("init_ready", int'(bus.cmd_ready), 0);
      chk("init_clr", int'(bus.reg_clr), 1);
      @(negedge clk);
      chk("ready_after_reset", int'(bus.cmd_ready), 1);
      chk("no_cmd_in_reset", int'(bus.reg_q), 0);

      // directed cases
      send(2'd0, 4'b1011, 3'd2, 1'b0, r);
      bus.cmd_valid = 1'b0;
      wait_idle();
      chk("shr_1011_2", int'(last_res), 4'b0010);

      send(2'd1, 4'b1011, 3'd3, 1'b1, r);
      bus.cmd_valid = 1'b0;
      wait_idle();
      chk("shl_1011_3", int'(last_res), 4'b1111);

      send(2'd2, 4'b1001, 3'd1, 1'b0, r);
      bus.cmd_valid = 1'b0;
      wait_idle();
      chk("ror_1001_1", int'(last_res), 4'b1100);

      s0 = ser_seen;
      send(2'd2, 4'b1001, 3'd7, 1'b0, r);
      bus.cmd_valid = 1'b0;
      wait_idle();
      chk("ror_1001_sat", int'(last_res), 4'b1001);
      chk("ror_sat_pulses", ser_seen - s0, 4);

      s0 = ser_seen;
      send(2'd1, 4'b0101, 3'd4, 1'b1, r);
      bus.cmd_valid = 1'b0;
      wait_idle();
      chk("shl_by4_fill", int'(last_res), 4'b1111);

      // back-to-back with valid held high
      s0 = ser_seen;
      send(2'd3, 4'b0110, 3'd0, 1'b0, r);
      a1 = last_acc;
      n2 = int'($urandom_range(0, 4));
      send(2'(($urandom) & 3), 4'($urandom), 3'(n2), 1'($urandom), r);
      a2 = last_acc;
      chk("b2b_gap_cnt0", a2 - a1, 3);
      send(2'd0, 4'hF, 3'd4, 1'b0, r);
      chk("b2b_gap", last_acc - a2, n2 + 3);
      bus.cmd_valid = 1'b0;
      wait_idle();
      chk("shr_by4_fill0", int'(last_res), 0);
      chk("b2b_ser_pulses", ser_seen - s0, n2 + 4);

      // randomized commands with random gaps
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom);
         d  = 4'($urandom);
         c  = 3'($urandom);
         f  = 1'($urandom);
         send(op, d, c, f, r);
         if ($urandom_range(0, 1) == 0) begin
            bus.cmd_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      bus.cmd_valid = 1'b0;
      wait_idle();

      // reset during the 2nd shift step
      s0 = ser_seen;
      send(2'd0, 4'b1101, 3'd4, 1'b1, r);
      bus.cmd_valid = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         #1;
         if (ser_seen >= s0 + 2) break;
      end
      chk("reached_step2", ser_seen - s0, 2);
      reset = 1'b1;
      #1;
      chk("midreset_outs", int'(outs()), int'(RST_OUTS));
      res_q.delete();
      ser_q.delete();
      d0 = done_seen;
      @(posedge clk);
      #1;
      chk("midreset_reg_q", int'(bus.reg_q), 0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("midreset_no_done", done_seen - d0, 0);

      send(2'd3, 4'b1000, 3'd1, 1'b0, r);
      bus.cmd_valid = 1'b0;
      wait_idle();
      chk("post_reset_cmd", int'(last_res), 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/shift_register_sequencer.md
# shift_register_sequencer

Controller that sequences one 4-bit universal shift register (hold / parallel load / shift right / shift left mux per bit, synchronous-reset D flip-flops). It accepts commands over a valid/ready handshake and performs each as a parallel load followed by 0–4 shift or rotate steps. It drives the register's select, data, serial-fill and clear inputs, and streams out the bits shifted off the register. It sits between the lab's command source (switch/FSM front end) and the register datapath.

## Interface
No parameters; width fixed at 4.
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00 LOAD_SHR, 01 LOAD_SHL, 10 LOAD_ROR (rotate right), 11 LOAD_ROL (rotate left)
- cmd_data  input  4  word loaded into the register
- cmd_count  input  3  number of shift/rotate steps; 0–4 used as is, 5–7 saturate to 4
- cmd_fill  input  1  bit fed into the vacated end on plain shifts
- reg_q  input  4  register output q[3:0]
- reg_s  output  2  register select: 00 hold, 01 load d, 10 shift right (q3←shr_in), 11 shift left (q0←shl_in)
- reg_d  output  4  register parallel data
- reg_shr_in  output  1  serial input at q[3]
- reg_shl_in  output  1  serial input at q[0]
- reg_clr  output  1  register synchronous reset
- ser_out  output  1  bit leaving the register this step
- ser_valid  output  1  ser_out valid (one per shift step)
- done  output  1  one-cycle pulse, command complete
- result  output  4  reg_q; valid while done=1

## Operation
- States: INIT, IDLE, LOAD, SHIFT, DONE. All outputs decode from registered state and registered command fields (op, data, fill, remaining count).
- INIT: reg_clr=1, reg_s=00, cmd_ready=0. Next state is always IDLE.
- IDLE: cmd_ready=1, reg_s=00. On cmd_valid&cmd_ready, capture op, data, fill and sat(count), then go to LOAD.
- LOAD: reg_s=01, reg_d=data. Next state is SHIFT if count>0, else DONE.
- SHIFT: reg_s=10 for SHR/ROR and 11 for SHL/ROL.
  - reg_shr_in = fill (SHR) or reg_q[0] (ROR).
  - reg_shl_in = fill (SHL) or reg_q[3] (ROL).
  - ser_valid=1; ser_out = reg_q[0] on right moves, reg_q[3] on left moves (the bit about to leave).
  - Each edge decrements remaining; on the edge where remaining=1, go to DONE.
- DONE: done=1, result=reg_q, reg_s=00. Next state is IDLE.
- Outside SHIFT: ser_valid=0, ser_out=0. Outside LOAD: reg_d=0. Unused serial input = 0.
- reg_clr = reset OR (state==INIT). It is asserted combinationally during reset so the register clears on every edge while reset is held.
- cmd_valid while cmd_ready=0 is ignored; the source must hold the command until it is accepted.

## Timing
- Reset (asynchronous): state→INIT immediately. Values while reset is held:
  - cmd_ready=0, done=0, ser_valid=0, ser_out=0, reg_s=00, reg_d=0, reg_shr_in=0, reg_shl_in=0, result=0, reg_clr=1.
- First edge after reset deasserts: INIT→IDLE. cmd_ready rises in the following cycle.
- Command accepted at edge E0. LOAD occupies the cycle E0–E1; the register holds data after E1.
- Shift step k (1..n) occupies cycle E(k)–E(k+1). done is high in the cycle after edge E(n+1).
- Accept-to-done latency is n+2 cycles; throughput is one command per n+3 cycles (the IDLE cycle is mandatory).
- Reset mid-command: the operation is aborted, done is not pulsed, and the register is cleared.
- Count 0: LOAD→DONE; done in the 2nd cycle after accept with result=cmd_data; no ser_valid.
- Rotate by 4 returns the original word. Shift by 4 yields {fill,fill,fill,fill}.

## Test plan
- Reset held for 3 cycles with cmd_valid=1 → reg_clr=1 each cycle, cmd_ready=0, no command accepted, reg_q=0000; cmd_ready=1 two cycles after release.
- LOAD_SHR, data=1011, count=2, fill=0:
  - ser_out stream 1,1 (LSB first).
  - done after 4 cycles, result=0010.
- LOAD_SHL, data=1011, count=3, fill=1:
  - ser_out stream 1,0,1.
  - result=1111.
- LOAD_ROR, data=1001, count=1 → result=1100. Same op with count=7 (saturated to 4) → result=1001 and exactly 4 ser_valid pulses.
- count=0, LOAD_ROL, data=0110 → no ser_valid, done 2 cycles after accept, result=0110. Back-to-back valid commands are accepted one IDLE cycle apart.
- Reset asserted during the 2nd shift step of LOAD_SHR count=4 → outputs return to reset values immediately, no done pulse, reg_q=0000 after the next edge; a new command then completes normally.
